// File: rtl/cond_block_unit.sv
// NZCV flag register, ARM condition evaluation and an If-Then block sequencer
// that overrides the instruction's own condition for up to MAX_IT following slots.
module cond_block_unit #(
  parameter int unsigned MAX_IT      = 4,
  parameter int unsigned CNT_W       = $clog2(MAX_IT + 1),
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              instr_valid,
  input  logic [3:0]        cond,
  input  logic              it_start,
  input  logic [3:0]        it_cond,
  input  logic [CNT_W-1:0]  it_len,
  input  logic [MAX_IT-1:0] it_te,
  input  logic [3:0]        alu_flags,
  input  logic [1:0]        flag_we,
  input  logic              flush,
  output logic              cond_ex,
  output logic [3:0]        eff_cond,
  output logic [3:0]        flags,
  output logic              it_active,
  output logic [CNT_W-1:0]  it_remaining,
  output logic              it_err
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_IT);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e              state_q, state_d;
  logic [3:0]          base_q, base_d;
  logic [MAX_IT-1:0]   te_q, te_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [3:0]          flags_q, flags_d;
  logic                pass;
  logic                te_then;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, ge, hi, gt, r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    ge = (n == v);
    hi = cf & ~z;
    gt = ~z & ge;
    unique case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cf;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = hi;
      3'd5:    r = ge;
      3'd6:    r = gt;
      default: r = 1'b1;
    endcase
    // Odd codes are the complement, except 1111 which is always-true like 1110
    if (c[3:1] != 3'b111) r = r ^ c[0];
    return r;
  endfunction

  assign it_active    = (state_q == StActive);
  assign it_remaining = rem_q;
  assign flags        = flags_q;

  always_comb begin
    // An AL base cannot be inverted, so every slot behaves as a then slot
    te_then  = te_q[0] | (base_q == 4'b1110);
    eff_cond = it_active ? {base_q[3:1], base_q[0] ^ ~te_then} : cond;
    pass     = cond_pass(eff_cond, flags_q);
    it_err   = instr_valid & it_start & it_active;
    if (!instr_valid)  cond_ex = 1'b0;
    else if (it_start) cond_ex = ~it_active;
    else               cond_ex = pass;
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    te_d    = te_q;
    rem_d   = rem_q;
    flags_d = flags_q;
    if (flush) begin
      state_d = StIdle;
      base_d  = '0;
      te_d    = '0;
      rem_d   = '0;
    end else if (en && instr_valid) begin
      if (cond_ex && !it_start) begin
        if (flag_we[1]) flags_d[3:2] = alu_flags[3:2];
        if (flag_we[0]) flags_d[1:0] = alu_flags[1:0];
      end
      unique case (state_q)
        StIdle: begin
          if (it_start) begin
            state_d = StActive;
            base_d  = it_cond;
            te_d    = it_te;
            if (it_len == '0)         rem_d = OneCnt;
            else if (it_len > MaxCnt) rem_d = MaxCnt;
            else                      rem_d = it_len;
          end
        end
        StActive: begin
          if (!it_start) begin
            if (rem_q == OneCnt) begin
              state_d = StIdle;
              base_d  = '0;
              te_d    = '0;
              rem_d   = '0;
            end else begin
              rem_d = rem_q - OneCnt;
              te_d  = te_q >> 1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      te_q    <= '0;
      rem_q   <= '0;
      flags_q <= RESET_FLAGS;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      te_q    <= te_d;
      rem_q   <= rem_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_cond_block_unit.sv
// Directed bench for cond_block_unit: flag writes, condition decode and IT sequencing.
module tb_cond_block_unit;

  localparam int unsigned MAX_IT = 4;
  localparam int unsigned CNT_W  = $clog2(MAX_IT + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en, instr_valid, it_start, flush;
  logic [3:0]        cond, it_cond, alu_flags;
  logic [CNT_W-1:0]  it_len;
  logic [MAX_IT-1:0] it_te;
  logic [1:0]        flag_we;
  logic              cond_ex, it_active, it_err;
  logic [3:0]        eff_cond, flags;
  logic [CNT_W-1:0]  it_remaining;

  int checks   = 0;
  int failures = 0;

  cond_block_unit #(.MAX_IT(MAX_IT), .RESET_FLAGS(4'b0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .instr_valid  (instr_valid),
    .cond         (cond),
    .it_start     (it_start),
    .it_cond      (it_cond),
    .it_len       (it_len),
    .it_te        (it_te),
    .alu_flags    (alu_flags),
    .flag_we      (flag_we),
    .flush        (flush),
    .cond_ex      (cond_ex),
    .eff_cond     (eff_cond),
    .flags        (flags),
    .it_active    (it_active),
    .it_remaining (it_remaining),
    .it_err       (it_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads flags through an always-true instruction, then stops writing
  task automatic set_flags(input logic [3:0] f);
    en = 1'b1; instr_valid = 1'b1; it_start = 1'b0;
    cond = 4'b1110; flag_we = 2'b11; alu_flags = f;
    tick();
    flag_we = 2'b00;
  endtask

  task automatic sweep(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      #1;
      chk(tag, 8'(cond_ex), 8'(exp[i]));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; instr_valid = 1'b0; it_start = 1'b0; flush = 1'b0;
    cond = 4'b0000; it_cond = 4'b0000; it_len = '0; it_te = '0;
    alu_flags = 4'b0000; flag_we = 2'b00;
    #3;
    chk("rst_flags", 8'(flags), 8'h0);
    chk("rst_active", 8'(it_active), 8'h0);
    chk("rst_rem", 8'(it_remaining), 8'h0);
    chk("rst_condex", 8'(cond_ex), 8'h0);
    #5 rst_n = 1'b1;
    tick();

    // NE with Z=0 passes, and writes Z
    en = 1'b1; instr_valid = 1'b1; cond = 4'b0001; flag_we = 2'b11; alu_flags = 4'b0100;
    #1 chk("ne_pass", 8'(cond_ex), 8'h1);
    tick();
    chk("flags_0100", 8'(flags), 8'h4);
    flag_we = 2'b00;
    #1 chk("ne_fail", 8'(cond_ex), 8'h0);

    // Split enables
    set_flags(4'b1111);
    flag_we = 2'b10; alu_flags = 4'b0000;
    tick();
    chk("split_nz", 8'(flags), 8'h3);
    flag_we = 2'b01; alu_flags = 4'b1100;
    tick();
    chk("split_cv", 8'(flags), 8'h0);
    // Failing condition must not write
    cond = 4'b0000; flag_we = 2'b11; alu_flags = 4'b1111;
    #1 chk("eq_fail", 8'(cond_ex), 8'h0);
    tick();
    chk("no_write", 8'(flags), 8'h0);
    flag_we = 2'b00;

    // Decode tables, bit i = expected for cond i
    set_flags(4'b1001);
    sweep("dec_1001", 16'hD65A);
    set_flags(4'b0111);
    sweep("dec_0111", 16'hEA65);
    set_flags(4'b0010);
    sweep("dec_0010", 16'hD5A6);

    // IT EQ, len 3, te 0101, Z=1; the IT itself must not write flags
    set_flags(4'b0100);
    it_start = 1'b1; it_cond = 4'b0000; it_len = 3'd3; it_te = 4'b0101;
    cond = 4'b1110; flag_we = 2'b11; alu_flags = 4'b1111;
    #1 chk("it_accept", 8'(cond_ex), 8'h1);
    chk("it_noerr", 8'(it_err), 8'h0);
    tick();
    chk("it_active", 8'(it_active), 8'h1);
    chk("it_rem3", 8'(it_remaining), 8'h3);
    chk("it_noflag", 8'(flags), 8'h4);
    it_start = 1'b0; flag_we = 2'b00;
    #1 chk("s1_eff", 8'(eff_cond), 8'h0);
    chk("s1_ex", 8'(cond_ex), 8'h1);
    tick();
    chk("s1_rem", 8'(it_remaining), 8'h2);
    en = 1'b0;
    #1 chk("s2_eff", 8'(eff_cond), 8'h1);
    chk("s2_ex", 8'(cond_ex), 8'h0);
    tick();
    tick();
    chk("stall_rem", 8'(it_remaining), 8'h2);
    en = 1'b1; instr_valid = 1'b0;
    #1 chk("bubble_ex", 8'(cond_ex), 8'h0);
    tick();
    chk("bubble_rem", 8'(it_remaining), 8'h2);
    instr_valid = 1'b1;
    tick();
    chk("s2_rem", 8'(it_remaining), 8'h1);
    // Nested IT is rejected and does not consume
    it_start = 1'b1; it_cond = 4'b1010; it_len = 3'd2;
    #1 chk("nest_err", 8'(it_err), 8'h1);
    chk("nest_ex", 8'(cond_ex), 8'h0);
    tick();
    chk("nest_rem", 8'(it_remaining), 8'h1);
    chk("nest_active", 8'(it_active), 8'h1);
    it_start = 1'b0; flag_we = 2'b01; alu_flags = 4'b0011;
    #1 chk("s3_eff", 8'(eff_cond), 8'h0);
    chk("s3_ex", 8'(cond_ex), 8'h1);
    tick();
    chk("s3_rem", 8'(it_remaining), 8'h0);
    chk("s3_idle", 8'(it_active), 8'h0);
    chk("s3_flags", 8'(flags), 8'h7);
    flag_we = 2'b00; cond = 4'b0001;
    #1 chk("post_eff", 8'(eff_cond), 8'h1);

    // Flush under stall
    it_start = 1'b1; it_cond = 4'b0000; it_len = 3'd2; it_te = 4'b0011;
    tick();
    chk("fl_rem", 8'(it_remaining), 8'h2);
    it_start = 1'b0; en = 1'b0; flush = 1'b1; cond = 4'b1110;
    flag_we = 2'b11; alu_flags = 4'b0000;
    tick();
    chk("fl_idle", 8'(it_active), 8'h0);
    chk("fl_rem0", 8'(it_remaining), 8'h0);
    chk("fl_flags", 8'(flags), 8'h7);
    flush = 1'b0; en = 1'b1; flag_we = 2'b00;

    // it_len = 0 behaves as 1
    it_start = 1'b1; it_len = 3'd0; it_te = 4'b0001;
    tick();
    chk("len0_rem", 8'(it_remaining), 8'h1);
    it_start = 1'b0;
    tick();
    chk("len0_done", 8'(it_active), 8'h0);

    // it_len = 7 clamps; AL base with else bits stays AL
    it_start = 1'b1; it_cond = 4'b1110; it_len = 3'd7; it_te = 4'b0000;
    tick();
    chk("len7_rem", 8'(it_remaining), 8'h4);
    it_start = 1'b0; cond = 4'b0000;
    #1 chk("al_eff", 8'(eff_cond), 8'hE);
    chk("al_ex", 8'(cond_ex), 8'h1);
    tick();
    chk("al_rem", 8'(it_remaining), 8'h3);

    // Asynchronous reset mid-block
    #2 rst_n = 1'b0;
    #1 chk("arst_active", 8'(it_active), 8'h0);
    chk("arst_flags", 8'(flags), 8'h0);
    chk("arst_rem", 8'(it_remaining), 8'h0);
    chk("arst_eff", 8'(eff_cond), 8'h0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_block_unit.md
Name: cond_block_unit

Overview:
Next-generation condition unit for the CPU control path. It holds the architectural NZCV flag register and evaluates all 15 ARM condition codes against it, with the same encoding and the same GE = (N == V) rule as the current condition checker. It adds a parametrised If-Then (IT) block sequencer so that up to MAX_IT following instructions execute under a shared base condition or its inverse. It also adds split flag write enables, stall, and flush. It sits between decode and the register-file/flag write-back enables.

Parameters:
MAX_IT, 4, maximum instructions covered by one IT block (legal range 1..8)
CNT_W, $clog2(MAX_IT+1), width of the remaining-count field
RESET_FLAGS, 4'b0000, NZCV value loaded on reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  pipeline advance; 0 = stall, no state change
instr_valid  in  1  current slot holds a real instruction
cond  in  4  instruction's own condition field
it_start  in  1  current instruction is an IT instruction
it_cond  in  4  IT base condition
it_len  in  CNT_W  IT block length, 1..MAX_IT
it_te  in  MAX_IT  per-slot then(1)/else(0); bit0 = first covered instruction
alu_flags  in  4  {N,Z,C,V} result of current instruction
flag_we  in  2  bit1 = write N,Z; bit0 = write C,V
flush  in  1  kill any active IT block
cond_ex  out  1  current instruction executes
eff_cond  out  4  condition actually evaluated
flags  out  4  registered NZCV
it_active  out  1  IT block in progress
it_remaining  out  CNT_W  covered instructions still to come
it_err  out  1  IT issued while a block is active (combinational)

Behaviour:
- Reset (async, rst_n=0): flags=RESET_FLAGS, it_active=0, it_remaining=0, internal base condition=0, te shift register=0. cond_ex, eff_cond and it_err follow combinationally from these values. Reset mid-block abandons the block immediately.
- Condition decode is combinational from eff_cond and the registered flags:
  - EQ/NE test Z.
  - CS/CC test C.
  - MI/PL test N.
  - VS/VC test V.
  - HI = C&~Z; LS = ~HI.
  - GE = (N==V); LT = ~GE.
  - GT = ~Z&GE; LE = ~GT.
  - 1110 and 1111 evaluate true.
- eff_cond:
  - it_active=0: eff_cond = cond.
  - it_active=1: eff_cond = {base[3:1], base[0] ^ ~te[0]}. An else slot inverts the condition LSB.
  - If base is 1110, all slots are forced to then, so the inversion never produces 1111.
- cond_ex = instr_valid & decode(eff_cond) & ~it_start_ok_nop. Detail:
  - IT instruction accepted (it_start while !it_active): cond_ex=1, no flag write.
  - IT instruction rejected (it_start while it_active): cond_ex=0 and it_err=instr_valid.
  - instr_valid=0: cond_ex=0.
- Flag register updates at the clock edge only when en & instr_valid & cond_ex & ~it_start.
  - flag_we[1]: N,Z <= alu_flags[3:2].
  - flag_we[0]: C,V <= alu_flags[1:0].
  - Unwritten bits hold their value.
  - The instruction's condition uses pre-update flags, so there is no bypass. Flags are visible to the next instruction.
- IT state machine: states IDLE (it_active=0) and ACTIVE.
  - IDLE -> ACTIVE on en & instr_valid & it_start. Loads:
    - base <= it_cond
    - te <= it_te
    - it_remaining <= clamp(it_len): 0 -> 1, >MAX_IT -> MAX_IT
  - ACTIVE consume on en & instr_valid & ~it_start:
    - it_remaining <= it_remaining-1; te <= te>>1.
    - If it_remaining was 1, return to IDLE and clear base and te.
    - Consumption happens whether or not cond_ex=1.
  - ACTIVE with it_start: no state change (error case above). The slot is not consumed.
  - en=0 or instr_valid=0: hold all state, in both states.
- flush (sampled at the edge, regardless of en):
  - Next state is IDLE with it_remaining=0.
  - Flags are not written that cycle.
  - Highest priority over load and consume.
- Latency: outputs for the instruction in the current slot are valid in the same cycle. State effects appear after the next rising edge.

Test Plan:
- Reset, then flags=0000, cond=0001 (NE), valid=1 -> cond_ex=1. Set flags via flag_we=11, alu_flags=0100 -> next cycle flags=0100, and NE now gives cond_ex=0.
- Split write: flags=1111, flag_we=10, alu_flags=0000 -> flags=0011. flag_we=01, alu_flags=1100 from 0011 -> flags=0000.
- IT with it_cond=0000 (EQ), it_len=3, it_te=0101, Z=1, then 3 instructions:
  - Required eff_cond = 0000, 0001, 0000.
  - Required cond_ex = 1, 0, 1.
  - it_remaining goes 3, 2, 1, 0, and it_active drops after the 3rd instruction.
- Stall mid-block: en=0 for 2 cycles after the 1st covered instruction -> it_remaining holds at 2. Bubble (instr_valid=0) -> no consume, cond_ex=0.
- Nested IT while active -> it_err=1, cond_ex=0, it_remaining unchanged. flush=1 with en=0 -> next cycle it_active=0, flags unchanged.
- Edge cases:
  - it_len=0 -> block of 1.
  - it_len=7 with MAX_IT=4 -> it_remaining=4.
  - rst_n low mid-block -> it_active=0 and flags=RESET_FLAGS immediately, without waiting for a clock.
